prog_loader: RTL and testbench

//  Writer side of the instruction-memory interface. Receives a framed byte stream over a

---
 rtl/prog_loader_pkg.sv | 25 ++
 rtl/prog_loader_word_assembler.sv | 35 +++
 rtl/prog_loader.sv | 143 ++++++++++++++
 tb/tb_prog_loader.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: frame constants and FSM state encoding.
// Imported by the loader top and its word-assembler sub-module.
package prog_loader_pkg;

  localparam int          PL_ADDR_W    = 10;
  localparam int          PL_DATA_W    = 32;
  localparam logic [7:0]  PL_MAGIC     = 8'hA5;
  localparam int          PL_MAX_WORDS = 1024;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CNT_HI = 3'd1,
    ST_CNT_LO = 3'd2,
    ST_WORD   = 3'd3,
    ST_CHECK  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } pl_state_e;

  // A word count is legal when it is non-zero and fits in instruction memory.
  function automatic logic pl_count_ok(input logic [15:0] cnt, input int max_words);
    return (cnt != 16'd0) && ({16'd0, cnt} <= 32'(max_words));
  endfunction

endpackage

// File: rtl/prog_loader_word_assembler.sv
// Collects stream bytes MSB first into a 32-bit word; o_word_valid marks the byte
// that completes a word, with o_word carrying that complete word in the same cycle.
module prog_loader_word_assembler
  import prog_loader_pkg::*;
#(
  parameter int DATA_W = PL_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  input  logic              i_shift,
  input  logic [7:0]        i_byte,
  output logic              o_word_valid,
  output logic [DATA_W-1:0] o_word
);

  logic [1:0]        r_idx;
  logic [DATA_W-9:0] r_shift;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_idx   <= 2'd0;
      r_shift <= '0;
    end else if (i_clear) begin
      r_idx   <= 2'd0;
    end else if (i_shift) begin
      r_idx   <= r_idx + 2'd1;
      r_shift <= {r_shift[DATA_W-17:0], i_byte};
    end
  end

  assign o_word_valid = i_shift && (r_idx == 2'd3);
  assign o_word       = {r_shift, i_byte};

endmodule

// File: rtl/prog_loader.sv
// Instruction-memory loader: parses MAGIC/count/data/checksum frames from a byte stream,
// writes words to mem_inst and releases the CPU reset only after a verified frame.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int         ADDR_W    = PL_ADDR_W,
  parameter int         DATA_W    = PL_DATA_W,
  parameter logic [7:0] MAGIC     = PL_MAGIC,
  parameter int         MAX_WORDS = PL_MAX_WORDS
) (
  input  logic              pl_in_clk,
  input  logic              pl_in_rst,
  input  logic [7:0]        pl_in_byte,
  input  logic              pl_in_valid,
  output logic              pl_out_ready,
  input  logic              pl_in_restart,
  output logic [ADDR_W-1:0] pl_out_addr,
  output logic [DATA_W-1:0] pl_out_data,
  output logic              pl_out_wren,
  output logic              pl_out_cpu_rst_n,
  output logic              pl_out_done,
  output logic              pl_out_err,
  output logic [10:0]       pl_out_words
);

  pl_state_e         r_state;
  pl_state_e         w_state_next;
  logic              w_ready;
  logic              w_xfer;
  logic [15:0]       w_cnt_full;
  logic              w_last_word;
  logic              w_word_valid;
  logic [DATA_W-1:0] w_word;

  logic [15:0]       r_cnt;
  logic [7:0]        r_checksum;
  logic [10:0]       r_words;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_wren;

  assign w_xfer      = pl_in_valid && w_ready;
  assign w_cnt_full  = {r_cnt[15:8], pl_in_byte};
  assign w_last_word = ({5'd0, r_words} + 16'd1) == r_cnt;

  prog_loader_word_assembler #(.DATA_W(DATA_W)) u_word_asm (
    .i_clk        (pl_in_clk),
    .i_rst_n      (pl_in_rst),
    .i_clear      (w_xfer && (r_state == ST_CNT_LO)),
    .i_shift      (w_xfer && (r_state == ST_WORD)),
    .i_byte       (pl_in_byte),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  always_ff @(posedge pl_in_clk) begin
    if (!pl_in_rst) r_state <= ST_IDLE;
    else            r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
        if (w_xfer && (pl_in_byte == MAGIC)) w_state_next = ST_CNT_HI;
      end
      ST_CNT_HI: begin
        w_ready = 1'b1;
        if (w_xfer) w_state_next = ST_CNT_LO;
      end
      ST_CNT_LO: begin
        w_ready = 1'b1;
        if (w_xfer) w_state_next = pl_count_ok(w_cnt_full, MAX_WORDS) ? ST_WORD : ST_ERR;
      end
      ST_WORD: begin
        w_ready = 1'b1;
        if (w_word_valid && w_last_word) w_state_next = ST_CHECK;
      end
      ST_CHECK: begin
        w_ready = 1'b1;
        if (w_xfer) w_state_next = (pl_in_byte == r_checksum) ? ST_DONE : ST_ERR;
      end
      ST_DONE, ST_ERR: begin
        if (pl_in_restart) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // The write strobe is registered, so a reset on the completing edge drops the write.
  always_ff @(posedge pl_in_clk) begin
    if (!pl_in_rst) begin
      r_cnt      <= 16'd0;
      r_checksum <= 8'd0;
      r_words    <= 11'd0;
      r_addr     <= '0;
      r_data     <= '0;
      r_wren     <= 1'b0;
    end else begin
      r_wren <= 1'b0;
      if (w_xfer) begin
        case (r_state)
          ST_IDLE: begin
            if (pl_in_byte == MAGIC) begin
              r_checksum <= 8'd0;
              r_words    <= 11'd0;
            end
          end
          ST_CNT_HI: begin
            r_cnt[15:8] <= pl_in_byte;
            r_checksum  <= r_checksum ^ pl_in_byte;
          end
          ST_CNT_LO: begin
            r_cnt[7:0] <= pl_in_byte;
            r_checksum <= r_checksum ^ pl_in_byte;
          end
          ST_WORD: begin
            r_checksum <= r_checksum ^ pl_in_byte;
            if (w_word_valid) begin
              r_data  <= w_word;
              r_addr  <= r_words[ADDR_W-1:0];
              r_wren  <= 1'b1;
              r_words <= r_words + 11'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign pl_out_ready     = w_ready;
  assign pl_out_addr      = r_addr;
  assign pl_out_data      = r_data;
  assign pl_out_wren      = r_wren;
  assign pl_out_words     = r_words;
  assign pl_out_done      = (r_state == ST_DONE);
  assign pl_out_err       = (r_state == ST_ERR);
  assign pl_out_cpu_rst_n = (r_state == ST_DONE);

endmodule

// File: tb/tb_prog_loader.sv
// Randomized self-checking bench for prog_loader; expected writes and status come from
// a frame parser that works on the whole byte stream at once.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_byte = 8'd0;
  logic        in_valid = 1'b0;
  logic        restart = 1'b0;
  logic        ready;
  logic [9:0]  addr;
  logic [31:0] data;
  logic        wren;
  logic        cpu_rst_n;
  logic        done;
  logic        err;
  logic [10:0] words;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  stim[$];
  logic [9:0]  obs_addr[$];
  logic [31:0] obs_data[$];
  logic [9:0]  exp_addr[$];
  logic [31:0] exp_data[$];
  int          exp_status;
  int          exp_words;

  prog_loader dut (
    .pl_in_clk        (clk),
    .pl_in_rst        (rst_n),
    .pl_in_byte       (in_byte),
    .pl_in_valid      (in_valid),
    .pl_out_ready     (ready),
    .pl_in_restart    (restart),
    .pl_out_addr      (addr),
    .pl_out_data      (data),
    .pl_out_wren      (wren),
    .pl_out_cpu_rst_n (cpu_rst_n),
    .pl_out_done      (done),
    .pl_out_err       (err),
    .pl_out_words     (words)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wren) begin
      obs_addr.push_back(addr);
      obs_data.push_back(data);
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: find MAGIC, read the count, slice words, XOR-verify the trailer.
  task automatic model_stream();
    int i;
    int cnt;
    logic [7:0] x;
    exp_addr.delete();
    exp_data.delete();
    exp_status = 0;
    exp_words  = 0;
    i = 0;
    while (i < stim.size() && stim[i] != 8'hA5) i++;
    if (i + 2 >= stim.size()) return;
    cnt = int'(stim[i+1]) * 256 + int'(stim[i+2]);
    x   = stim[i+1] ^ stim[i+2];
    if (cnt == 0 || cnt > 1024) begin
      exp_status = 2;
      return;
    end
    for (int k = 0; k < cnt; k++) begin
      int b = i + 3 + 4 * k;
      exp_addr.push_back(10'(k));
      exp_data.push_back({stim[b], stim[b+1], stim[b+2], stim[b+3]});
      x = x ^ stim[b] ^ stim[b+1] ^ stim[b+2] ^ stim[b+3];
    end
    exp_words  = cnt;
    exp_status = (stim[i + 3 + 4 * cnt] == x) ? 1 : 2;
  endtask

  // Caller is at a negedge; byte is presented for one edge, then valid drops for gap cycles.
  task automatic send_byte(input logic [7:0] b, input int gap);
    in_byte  = b;
    in_valid = 1'b1;
    check_eq("ready_on_send", 64'(ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic run_stream(input string tag, input int gap_max);
    obs_addr.delete();
    obs_data.delete();
    model_stream();
    foreach (stim[j]) send_byte(stim[j], (gap_max == 0) ? 0 : int'($urandom_range(gap_max, 0)));
    repeat (3) @(negedge clk);
    check_eq({tag, "_nwr"}, 64'(obs_addr.size()), 64'(exp_addr.size()));
    for (int k = 0; k < exp_addr.size() && k < obs_addr.size(); k++) begin
      check_eq({tag, "_addr"}, 64'(obs_addr[k]), 64'(exp_addr[k]));
      check_eq({tag, "_data"}, 64'(obs_data[k]), 64'(exp_data[k]));
    end
    check_eq({tag, "_done"}, 64'(done), 64'(exp_status == 1));
    check_eq({tag, "_err"}, 64'(err), 64'(exp_status == 2));
    check_eq({tag, "_cpurst"}, 64'(cpu_rst_n), 64'(exp_status == 1));
    check_eq({tag, "_ready"}, 64'(ready), 64'(exp_status == 0));
    check_eq({tag, "_words"}, 64'(words), 64'(exp_words));
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check_eq("restart_done", 64'(done), 64'd0);
    check_eq("restart_err", 64'(err), 64'd0);
    check_eq("restart_ready", 64'(ready), 64'd1);
  endtask

  task automatic load_frame1(input logic [7:0] chk);
    logic [7:0] f1[11] = '{8'hA5, 8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                           8'hAC, 8'h01, 8'h00, 8'h00};
    foreach (f1[j]) stim.push_back(f1[j]);
    stim.push_back(chk);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_addr"}, 64'(addr), 64'd0);
    check_eq({tag, "_data"}, 64'(data), 64'd0);
    check_eq({tag, "_wren"}, 64'(wren), 64'd0);
    check_eq({tag, "_cpurst"}, 64'(cpu_rst_n), 64'd0);
    check_eq({tag, "_done"}, 64'(done), 64'd0);
    check_eq({tag, "_err"}, 64'(err), 64'd0);
    check_eq({tag, "_words"}, 64'(words), 64'd0);
    check_eq({tag, "_ready"}, 64'(ready), 64'd1);
  endtask

  initial begin
    logic [7:0] pre[5] = '{8'hA5, 8'h00, 8'h01, 8'h20, 8'h08};
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("reset");

    stim.delete(); load_frame1(8'h82); run_stream("good", 0); pulse_restart();
    stim.delete(); load_frame1(8'h83); run_stream("badchk", 0); pulse_restart();
    stim.delete(); stim = '{8'hA5, 8'h00, 8'h00}; run_stream("cnt0", 0); pulse_restart();
    stim.delete(); stim = '{8'hA5, 8'h04, 8'h01}; run_stream("cnt1025", 0); pulse_restart();
    stim.delete(); stim = '{8'h00, 8'hFF, 8'h5A}; load_frame1(8'h82); run_stream("junk", 0);

    // Restart with a valid MAGIC in DONE must not consume it; 00 00 is then idle junk.
    in_byte = 8'hA5; in_valid = 1'b1; restart = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; restart = 1'b0;
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    @(negedge clk);
    check_eq("rst_valid_err", 64'(err), 64'd0);
    check_eq("rst_valid_ready", 64'(ready), 64'd1);

    obs_addr.delete(); obs_data.delete();
    foreach (pre[j]) send_byte(pre[j], 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_vals("midrst");
    repeat (3) @(negedge clk);
    check_eq("midrst_nwr", 64'(obs_addr.size()), 64'd0);

    // Reset on the very edge that completes a word drops that write.
    foreach (pre[j]) send_byte(pre[j], 0);
    send_byte(8'h00, 0);
    in_byte = 8'h05; in_valid = 1'b1; rst_n = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("edgerst_nwr", 64'(obs_addr.size()), 64'd0);
    check_eq("edgerst_words", 64'(words), 64'd0);

    stim.delete(); load_frame1(8'h82); run_stream("afterrst", 0); pulse_restart();
    stim.delete(); load_frame1(8'h82);
    obs_addr.delete(); obs_data.delete(); model_stream();
    foreach (stim[j]) send_byte(stim[j], 3);
    check_eq("gap_nwr", 64'(obs_addr.size()), 64'd2);
    check_eq("gap_data1", 64'(obs_data.size() > 1 ? obs_data[1] : 32'h0), 64'h AC010000);
    check_eq("gap_done", 64'(done), 64'd1);
    pulse_restart();

    for (int it = 0; it < 40; it++) begin
      int cnt;
      logic [7:0] x;
      stim.delete();
      repeat ($urandom_range(3, 0)) begin
        logic [7:0] g = 8'($urandom);
        if (g == 8'hA5) g = 8'h5A;
        stim.push_back(g);
      end
      if ($urandom_range(9, 0) == 0)
        cnt = ($urandom_range(1, 0) == 0) ? 0 : int'($urandom_range(65535, 1025));
      else
        cnt = int'($urandom_range(6, 1));
      stim.push_back(8'hA5);
      stim.push_back(8'(cnt >> 8));
      stim.push_back(8'(cnt));
      if (cnt >= 1 && cnt <= 1024) begin
        x = 8'(cnt >> 8) ^ 8'(cnt);
        repeat (4 * cnt) begin
          logic [7:0] d = 8'($urandom);
          stim.push_back(d);
          x = x ^ d;
        end
        stim.push_back(($urandom_range(9, 0) < 7) ? x : (x ^ 8'(1 << $urandom_range(7, 0))));
      end
      run_stream("rand", 2);
      pulse_restart();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
